kernel_2mm_dispatch: RTL and testbench
======================================

KERNEL_2MM_DISPATCH -- requirements
Module: kernel_2mm_dispatch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, job-queue depth; power of 2, range 2..16.
REQ-002 clock  in  1  sole clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 job_valid  in  1  job descriptor offered.
REQ-005 job_ready  out  1  queue can accept; transfer when job_valid && job_ready.
REQ-006 job_tag  in  8  caller tag, returned on completion.
REQ-007 job_alpha, job_beta  in  32 each  scalar arguments.
REQ-008 job_a, job_b, job_c, job_d  in  64 each  matrix base addresses.
REQ-009 k_start  out  1  kernel call valid.
REQ-010 k_busy  in  1  kernel call back-pressure; call accepted when k_start && !k_busy.
REQ-011 k_done  in  1  kernel return valid.
REQ-012 k_stall  out  1  return back-pressure; return accepted when k_done && !k_stall.
REQ-013 k_alpha, k_beta  out  32 each; k_a, k_b, k_c, k_d  out  64 each  kernel arguments.
REQ-014 cmpl_valid  out  1; cmpl_ready  in  1  completion handshake.
REQ-015 cmpl_tag  out  8; cmpl_cycles  out  32  tag and kernel run time of the finished job.
REQ-016 err_done  out  1  sticky: k_done seen while no call outstanding.

Function
REQ-017 Jobs queue in a FIFO_DEPTH-entry FIFO; job_ready = !full, registered, independent of job_valid.
REQ-018 FSM states IDLE, CALL, RUN; at most one kernel call outstanding.
REQ-019 IDLE: FIFO non-empty -> pop head into argument registers, go CALL; otherwise stay.
REQ-020 IDLE also waits while cmpl_valid && !cmpl_ready, so a completion is never overwritten.
REQ-021 CALL: k_start = 1; k_start && !k_busy -> go RUN, clear cycle counter to 1.
REQ-022 RUN: k_start = 0; counter +1 per cycle, saturating at 0xFFFFFFFF.
REQ-023 RUN, k_done && !k_stall: load cmpl_tag and cmpl_cycles from the counter value in that cycle, set cmpl_valid, go IDLE.
REQ-024 k_stall = cmpl_valid && !cmpl_ready; no combinational path from k_done to k_stall.
REQ-025 cmpl_valid clears on cmpl_valid && cmpl_ready unless a new completion loads in the same cycle.
REQ-026 k_alpha..k_d held stable from entry to CALL until the return is accepted.
REQ-027 Latency: job accepted at edge T into an empty FIFO in IDLE -> k_start high from edge T+2.
REQ-028 Simultaneous push and pop in one cycle are both performed; count unchanged.
REQ-029 Full FIFO: job_ready = 0, no push. Empty FIFO: no pop.
REQ-030 k_done in IDLE or CALL: ignored for FSM and counter; err_done set until reset.
REQ-031 k_busy is don't-care outside CALL.

Reset
REQ-032 Reset clears FIFO to empty and sets FSM to IDLE.
REQ-033 Reset clears k_start, cmpl_valid, err_done, counter, cmpl_tag, cmpl_cycles and argument registers to 0.
REQ-034 job_ready is 0 during reset and 1 on the first cycle after it.
REQ-035 Reset mid-call abandons the job with no completion; the kernel receives the same reset.

Structure
REQ-036 Shared package kernel_2mm_pkg holds the job descriptor struct (tag, alpha, beta, a, b, c, d; 328 bits), FSM state enum, and width constants (TAG_W=8, SCALAR_W=32, ADDR_W=64, CYC_W=32).
REQ-037 Queue is one sub-module, kernel_2mm_job_fifo: parameterised depth, descriptor payload, full/empty/count outputs.
REQ-038 FSM, argument registers, counter and completion register live in kernel_2mm_dispatch.

Verification
REQ-039 Single job (tag 0x11, alpha 2, beta 3, A=0x1000), k_busy 0, k_done 5 cycles after accept -> k_start at T+2 for 1 cycle; cmpl_tag 0x11, cmpl_cycles 5; args stable throughout.
REQ-040 k_busy held 3 cycles in CALL -> k_start high 4 cycles, arguments unchanged, one call accepted.
REQ-041 Push 5 jobs back-to-back, FIFO_DEPTH 4, kernel busy -> 5th job stalls with job_ready 0 until first pop; all 5 complete in order, tags 0..4.
REQ-042 cmpl_ready 0 when second job finishes -> k_stall 1 and k_done held; first completion kept; after cmpl_ready 1, both delivered in order.
REQ-043 k_done pulsed in IDLE -> err_done 1 and sticky, no cmpl_valid; reset clears it.
REQ-044 Reset asserted in RUN -> next cycle k_start 0, cmpl_valid 0, job_ready 1; FIFO empty.

Source files
------------

// File: rtl/kernel_2mm_pkg.sv
// Shared types for the 2mm kernel dispatcher.
//   job_desc_t       : one queued job (tag, two scalars, four matrix bases).
//   dispatch_state_t : dispatcher FSM state.
//   sat_inc          : saturating increment for the run-time counter.
package kernel_2mm_pkg;

  localparam int TAG_W    = 8;
  localparam int SCALAR_W = 32;
  localparam int ADDR_W   = 64;
  localparam int CYC_W    = 32;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [SCALAR_W-1:0] alpha;
    logic [SCALAR_W-1:0] beta;
    logic [ADDR_W-1:0]   a;
    logic [ADDR_W-1:0]   b;
    logic [ADDR_W-1:0]   c;
    logic [ADDR_W-1:0]   d;
  } job_desc_t;

  localparam int JOB_W = $bits(job_desc_t);

  typedef enum logic [1:0] {
    IDLE,
    CALL,
    RUN
  } dispatch_state_t;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/kernel_2mm_job_fifo.sv
// Job descriptor queue.
//   clock, reset       : clock and synchronous active-high reset
//   push, push_data    : write one descriptor (ignored when full)
//   pop                : drop the head descriptor (ignored when empty)
//   head               : current head descriptor (valid when !empty)
//   full, empty, count : occupancy
module kernel_2mm_job_fifo
  import kernel_2mm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  job_desc_t              push_data,
  input  logic                   pop,
  output job_desc_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  job_desc_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read straight from the array so the dispatcher can capture it
  // in the same cycle it pops.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/kernel_2mm.sv
// kernel_2mm_dispatch: queues 2mm job descriptors and issues them one at a
// time to the kernel, timing each call and returning tag + run time.
//   clock, reset                     : clock, synchronous active-high reset
//   job_valid/job_ready, job_*       : job descriptor input
//   k_start/k_busy, k_alpha..k_d     : kernel call handshake and arguments
//   k_done/k_stall                   : kernel return handshake
//   cmpl_valid/cmpl_ready, cmpl_tag, cmpl_cycles : completion output
//   err_done                         : sticky, k_done seen with no call out
module kernel_2mm_dispatch
  import kernel_2mm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [TAG_W-1:0]    job_tag,
  input  logic [SCALAR_W-1:0] job_alpha,
  input  logic [SCALAR_W-1:0] job_beta,
  input  logic [ADDR_W-1:0]   job_a,
  input  logic [ADDR_W-1:0]   job_b,
  input  logic [ADDR_W-1:0]   job_c,
  input  logic [ADDR_W-1:0]   job_d,
  output logic                k_start,
  input  logic                k_busy,
  input  logic                k_done,
  output logic                k_stall,
  output logic [SCALAR_W-1:0] k_alpha,
  output logic [SCALAR_W-1:0] k_beta,
  output logic [ADDR_W-1:0]   k_a,
  output logic [ADDR_W-1:0]   k_b,
  output logic [ADDR_W-1:0]   k_c,
  output logic [ADDR_W-1:0]   k_d,
  output logic                cmpl_valid,
  input  logic                cmpl_ready,
  output logic [TAG_W-1:0]    cmpl_tag,
  output logic [CYC_W-1:0]    cmpl_cycles,
  output logic                err_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  dispatch_state_t  state_reg, state_next;
  job_desc_t        job_in, fifo_head, args_reg;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, count_after;
  logic             ready_reg;
  logic             k_start_reg, k_start_next;
  logic [CYC_W-1:0] cycle_reg, cycle_next;
  logic             cmpl_valid_reg, cmpl_valid_next;
  logic [TAG_W-1:0] cmpl_tag_reg, cmpl_tag_next;
  logic [CYC_W-1:0] cmpl_cycles_reg, cmpl_cycles_next;
  logic             err_reg, err_next;
  logic             call_ack, ret_ack;

  always_comb begin
    job_in       = '0;
    job_in.tag   = job_tag;
    job_in.alpha = job_alpha;
    job_in.beta  = job_beta;
    job_in.a     = job_a;
    job_in.b     = job_b;
    job_in.c     = job_c;
    job_in.d     = job_d;
  end

  kernel_2mm_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (job_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // job_ready is the registered "not full after this cycle" flag; it is held
  // low through reset, so the full flag also gates the push.
  assign fifo_push   = job_valid && ready_reg && !fifo_full;
  assign count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  // Return back-pressure depends only on the completion register and the
  // consumer, never on k_done.
  assign k_stall  = cmpl_valid_reg && !cmpl_ready;
  assign call_ack = k_start_reg && !k_busy;
  assign ret_ack  = (state_reg == RUN) && k_done && !k_stall;

  always_comb begin
    state_next       = state_reg;
    fifo_pop         = 1'b0;
    k_start_next     = 1'b0;
    cycle_next       = cycle_reg;
    cmpl_valid_next  = cmpl_valid_reg;
    cmpl_tag_next    = cmpl_tag_reg;
    cmpl_cycles_next = cmpl_cycles_reg;
    err_next         = err_reg;

    if (cmpl_valid_reg && cmpl_ready) cmpl_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Hold off while a completion is stuck so it cannot be overwritten.
        if (!fifo_empty && !k_stall) begin
          fifo_pop   = 1'b1;
          state_next = CALL;
        end
      end
      CALL: begin
        // k_start rises the cycle after the arguments are captured and
        // drops on the edge the call is accepted.
        k_start_next = !call_ack;
        if (call_ack) begin
          state_next = RUN;
          cycle_next = CYC_W'(1);
        end
      end
      RUN: begin
        cycle_next = sat_inc(cycle_reg);
        if (ret_ack) begin
          cmpl_valid_next  = 1'b1;
          cmpl_tag_next    = args_reg.tag;
          cmpl_cycles_next = cycle_reg;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (k_done && (state_reg != RUN)) err_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      ready_reg       <= 1'b0;
      args_reg        <= '0;
      k_start_reg     <= 1'b0;
      cycle_reg       <= '0;
      cmpl_valid_reg  <= 1'b0;
      cmpl_tag_reg    <= '0;
      cmpl_cycles_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ready_reg       <= (count_after != DEPTH_CNT);
      if (fifo_pop) args_reg <= fifo_head;
      k_start_reg     <= k_start_next;
      cycle_reg       <= cycle_next;
      cmpl_valid_reg  <= cmpl_valid_next;
      cmpl_tag_reg    <= cmpl_tag_next;
      cmpl_cycles_reg <= cmpl_cycles_next;
      err_reg         <= err_next;
    end
  end

  assign job_ready   = ready_reg;
  assign k_start     = k_start_reg;
  assign k_alpha     = args_reg.alpha;
  assign k_beta      = args_reg.beta;
  assign k_a         = args_reg.a;
  assign k_b         = args_reg.b;
  assign k_c         = args_reg.c;
  assign k_d         = args_reg.d;
  assign cmpl_valid  = cmpl_valid_reg;
  assign cmpl_tag    = cmpl_tag_reg;
  assign cmpl_cycles = cmpl_cycles_reg;
  assign err_done    = err_reg;

endmodule

// File: tb/tb_kernel_2mm_dispatch.sv
// Self-checking bench for kernel_2mm_dispatch: a table of single-job vectors
// followed by hand-written queue-full, completion back-pressure, stray
// k_done and mid-run reset sequences. A small reactive kernel model answers
// calls with a programmable busy time and run length.
module tb_kernel_2mm_dispatch;
  import kernel_2mm_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        job_valid = 1'b0, job_ready;
  logic [7:0]  job_tag = '0;
  logic [31:0] job_alpha = '0, job_beta = '0;
  logic [63:0] job_a = '0, job_b = '0, job_c = '0, job_d = '0;
  logic        k_start, k_busy = 1'b0, k_done = 1'b0, k_stall;
  logic [31:0] k_alpha, k_beta;
  logic [63:0] k_a, k_b, k_c, k_d;
  logic        cmpl_valid, cmpl_ready = 1'b1;
  logic [7:0]  cmpl_tag;
  logic [31:0] cmpl_cycles;
  logic        err_done;

  kernel_2mm_dispatch #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
    .job_alpha(job_alpha), .job_beta(job_beta),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d),
    .k_start(k_start), .k_busy(k_busy), .k_done(k_done), .k_stall(k_stall),
    .k_alpha(k_alpha), .k_beta(k_beta),
    .k_a(k_a), .k_b(k_b), .k_c(k_c), .k_d(k_d),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
    .cmpl_tag(cmpl_tag), .cmpl_cycles(cmpl_cycles), .err_done(err_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Kernel model state
  bit  model_en = 1'b0;
  int  busy_len = 0, run_len = 5;
  int  mphase = 0, bcnt = 0, rcnt = 0, rlen = 0;
  int  calls = 0, kstart_cycles = 0;
  bit  stall_s = 1'b0, rst_s = 1'b1;
  bit  arg_chk = 1'b0, args_bad = 1'b0;
  logic [319:0] exp_args = '0;
  logic [7:0]  got_tag[$];
  logic [31:0] got_cyc[$];

  // Mid-cycle monitor: samples DUT outputs away from the rising edge.
  initial forever begin
    @(negedge clock);
    stall_s = k_stall;
    rst_s   = reset;
    if (k_start) kstart_cycles++;
    if (cmpl_valid && cmpl_ready && !reset) begin
      got_tag.push_back(cmpl_tag);
      got_cyc.push_back(cmpl_cycles);
      $display("completion tag=0x%02h cycles=%0d", cmpl_tag, cmpl_cycles);
    end
    if (arg_chk && (k_start || mphase != 0) &&
        ({k_alpha, k_beta, k_a, k_b, k_c, k_d} !== exp_args))
      args_bad = 1'b1;
  end

  // Reactive kernel: busy for busy_len k_start cycles, then returns k_done
  // sampled run_len edges after the call is accepted, held until not stalled.
  initial forever begin
    @(posedge clock);
    #1;
    if (rst_s || !model_en) begin
      mphase = 0;
      bcnt   = 0;
      if (model_en) begin
        k_busy = 1'b0;
        k_done = 1'b0;
      end
    end else begin
      case (mphase)
        0: begin
          if (k_start) begin
            if (bcnt < busy_len) begin
              k_busy = 1'b1;
              bcnt++;
            end else begin
              k_busy = 1'b0;
              mphase = 1;
              rcnt   = 0;
              rlen   = run_len;
              calls++;
            end
          end else begin
            k_busy = 1'b0;
          end
        end
        1: begin
          k_busy = 1'b0;
          if (rcnt + 1 >= rlen) begin
            k_done = 1'b1;
            mphase = 2;
          end
          rcnt++;
        end
        default: begin
          if (!stall_s) begin
            k_done = 1'b0;
            mphase = 0;
            bcnt   = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] alpha, beta;
    logic [63:0] a, b, c, d;
    int          busy;
    int          run;
    logic [31:0] exp_cycles;
    int          exp_kstart;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_job(input logic [7:0] t);
    job_tag   = t;
    job_alpha = 32'h100 + 32'(t);
    job_beta  = 32'h200 + 32'(t);
    job_a     = 64'h1_0000 + 64'(t);
    job_b     = 64'h2_0000 + 64'(t);
    job_c     = 64'h3_0000 + 64'(t);
    job_d     = 64'h4_0000 + 64'(t);
  endtask

  initial begin
    int n, idx, stall_n, calls0, ks0;
    bit acc;
    logic [7:0]  exp_tags[6];
    logic [31:0] exp_cycs[6];

    vecs[0] = '{8'h11, 32'd2, 32'd3, 64'h1000, 64'h2000, 64'h3000, 64'h4000, 0, 5, 32'd5, 1};
    vecs[1] = '{8'h22, 32'hDEADBEEF, 32'h1, 64'hFFFF_FFFF_FFFF_F000, 64'h0123_4567_89AB_CDEF,
                64'h8000_0000_0000_0000, 64'h1, 3, 2, 32'd2, 4};
    vecs[2] = '{8'h33, 32'h5A5A5A5A, 32'hA5A5A5A5, 64'h10, 64'h20, 64'h30, 64'h40, 1, 1, 32'd1, 2};
    vecs[3] = '{8'hFF, 32'hFFFFFFFF, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 0, 12, 32'd12, 1};

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_job_ready", job_ready, 0);
    check("rst_k_start", k_start, 0);
    check("rst_cmpl_valid", cmpl_valid, 0);
    check("rst_err_done", err_done, 0);
    check("rst_cmpl_tag", cmpl_tag, 0);
    check("rst_cmpl_cycles", cmpl_cycles, 0);
    check("rst_k_a", k_a, 0);
    check("rst_k_alpha", k_alpha, 0);
    reset = 1'b0;
    tick();
    check("post_rst_job_ready", job_ready, 1);
    check("post_rst_k_stall", k_stall, 0);

    // Table: single jobs with varied arguments, busy time and run length
    model_en   = 1'b1;
    cmpl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      busy_len = vecs[i].busy;
      run_len  = vecs[i].run;
      exp_args = {vecs[i].alpha, vecs[i].beta, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d};
      args_bad = 1'b0;
      arg_chk  = 1'b1;
      kstart_cycles = 0;
      calls0   = calls;
      got_tag.delete();
      got_cyc.delete();
      job_tag = vecs[i].tag; job_alpha = vecs[i].alpha; job_beta = vecs[i].beta;
      job_a = vecs[i].a; job_b = vecs[i].b; job_c = vecs[i].c; job_d = vecs[i].d;
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      check($sformatf("v%0d_k_start_T0", i), k_start, 0);
      tick();
      check($sformatf("v%0d_k_start_T1", i), k_start, 0);
      tick();
      check($sformatf("v%0d_k_start_T2", i), k_start, 1);
      n = 0;
      while (got_tag.size() == 0 && n < 200) begin
        tick();
        n++;
      end
      repeat (2) tick();
      if (got_tag.size() == 0) begin
        check($sformatf("v%0d_cmpl_seen", i), 0, 1);
      end else begin
        check($sformatf("v%0d_cmpl_tag", i), got_tag[0], vecs[i].tag);
        check($sformatf("v%0d_cmpl_cycles", i), got_cyc[0], vecs[i].exp_cycles);
      end
      check($sformatf("v%0d_cmpl_count", i), got_tag.size(), 1);
      check($sformatf("v%0d_k_start_cycles", i), kstart_cycles, vecs[i].exp_kstart);
      check($sformatf("v%0d_calls", i), calls - calls0, 1);
      check($sformatf("v%0d_args_stable", i), args_bad, 0);
      check($sformatf("v%0d_k_alpha_held", i), k_alpha, vecs[i].alpha);
      check($sformatf("v%0d_cmpl_valid_clr", i), cmpl_valid, 0);
      arg_chk = 1'b0;
      repeat (2) tick();
    end

    // Queue full: a long job keeps the FSM in RUN while five jobs arrive
    got_tag.delete();
    got_cyc.delete();
    busy_len = 0;
    run_len  = 20;
    set_job(8'hAA);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    n = 0;
    while (mphase != 1 && n < 20) begin
      tick();
      n++;
    end
    check("full_blocker_called", mphase, 1);
    run_len  = 3;
    busy_len = 1;
    idx = 0;
    stall_n = 0;
    set_job(8'd0);
    job_valid = 1'b1;
    n = 0;
    while (idx < 5 && n < 300) begin
      acc = job_ready;
      tick();
      n++;
      if (acc) begin
        idx++;
        if (idx == 4) begin
          check("full_job_ready_low", job_ready, 0);
          check("full_no_pop_yet", got_tag.size(), 0);
        end
        if (idx == 5) check("full_fifth_after_pop", got_tag.size(), 1);
        if (idx < 5) set_job(8'(idx));
        else job_valid = 1'b0;
      end else if (idx == 4) begin
        stall_n++;
      end
    end
    job_valid = 1'b0;
    check("full_all_pushed", idx, 5);
    check("full_stalled", (stall_n > 5) ? 1 : 0, 1);
    n = 0;
    while (got_tag.size() < 6 && n < 400) begin
      tick();
      n++;
    end
    exp_tags = '{8'hAA, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    exp_cycs = '{32'd20, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
    check("full_cmpl_count", got_tag.size(), 6);
    for (int j = 0; j < 6; j++) begin
      if (j < got_tag.size()) begin
        check($sformatf("full_tag%0d", j), got_tag[j], exp_tags[j]);
        check($sformatf("full_cyc%0d", j), got_cyc[j], exp_cycs[j]);
      end
    end
    repeat (3) tick();

    // Completion back-pressure: first completion held, second job waits
    got_tag.delete();
    got_cyc.delete();
    busy_len   = 0;
    run_len    = 3;
    cmpl_ready = 1'b0;
    set_job(8'h50);
    job_valid = 1'b1;
    tick();
    set_job(8'h51);
    tick();
    job_valid = 1'b0;
    n = 0;
    while (!cmpl_valid && n < 100) begin
      tick();
      n++;
    end
    check("bp_cmpl_valid", cmpl_valid, 1);
    check("bp_cmpl_tag", cmpl_tag, 8'h50);
    check("bp_cmpl_cycles", cmpl_cycles, 3);
    check("bp_k_stall", k_stall, 1);
    ks0 = kstart_cycles;
    repeat (6) tick();
    check("bp_held_valid", cmpl_valid, 1);
    check("bp_held_tag", cmpl_tag, 8'h50);
    check("bp_second_waits", kstart_cycles - ks0, 0);
    check("bp_none_delivered", got_tag.size(), 0);
    cmpl_ready = 1'b1;
    #1;
    check("bp_k_stall_released", k_stall, 0);
    n = 0;
    while (got_tag.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    check("bp_cmpl_count", got_tag.size(), 2);
    if (got_tag.size() >= 2) begin
      check("bp_first_tag", got_tag[0], 8'h50);
      check("bp_second_tag", got_tag[1], 8'h51);
      check("bp_second_cycles", got_cyc[1], 3);
    end
    repeat (3) tick();

    // Stray k_done in IDLE
    model_en = 1'b0;
    k_busy   = 1'b0;
    k_done   = 1'b1;
    tick();
    k_done = 1'b0;
    check("err_set", err_done, 1);
    check("err_no_cmpl", cmpl_valid, 0);
    repeat (4) tick();
    check("err_sticky", err_done, 1);
    check("err_still_no_cmpl", cmpl_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_cleared", err_done, 0);
    tick();

    // Reset in RUN with a second job queued
    model_en = 1'b1;
    busy_len = 0;
    run_len  = 50;
    set_job(8'h60);
    job_valid = 1'b1;
    tick();
    set_job(8'h61);
    tick();
    job_valid = 1'b0;
    n = 0;
    while (mphase != 1 && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    got_tag.delete();
    got_cyc.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_k_start", k_start, 0);
    check("mid_rst_cmpl_valid", cmpl_valid, 0);
    tick();
    check("mid_rst_job_ready", job_ready, 1);
    kstart_cycles = 0;
    repeat (60) tick();
    check("mid_rst_no_call", kstart_cycles, 0);
    check("mid_rst_no_cmpl", got_tag.size(), 0);
    check("mid_rst_no_err", err_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
